// File: rtl/ram_stream_fifo.sv
// rtl/ram_stream_fifo.sv - stream FIFO over an external RAM with registered read data
// The output word lives in the RAM read register, so at most DEPTH words wait in the RAM plus one at the output.
module ram_stream_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_payload,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_payload,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  ram_wr_en,
    output logic [MASK_WIDTH-1:0] ram_wr_mask,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic                  out_valid_q, out_valid_d;
    logic                  push_fire;
    logic                  read_fire;

    // ram_count is registered, so a word written this cycle is never eligible for reading yet.
    assign push_ready = (ram_count_q != DEPTH) && !reset && !flush;
    assign push_fire  = push_valid && push_ready;
    assign read_fire  = (ram_count_q != '0) && (!out_valid_q || pop_ready) && !reset && !flush;

    assign ram_wr_en   = push_fire;
    assign ram_wr_mask = '1;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = push_payload;
    assign ram_rd_en   = read_fire;
    assign ram_rd_addr = rd_ptr_q;

    assign pop_valid   = out_valid_q;
    assign pop_payload = ram_rd_data;
    assign occupancy   = ram_count_q + (ADDR_WIDTH+1)'(out_valid_q);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_count_d = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (read_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            ram_count_d = ram_count_q + (ADDR_WIDTH+1)'(push_fire) - (ADDR_WIDTH+1)'(read_fire);
            if (read_fire) begin
                out_valid_d = 1'b1;
            end else if (pop_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
